param_fifo: RTL

Parametrised synchronous FIFO that replaces the fixed 8-bit/16-entry queue used between the switch/button input stage and the display stage of the lab designs. It adds configurable data width and depth, full-capacity use of every entry, same-cycle push and pop, programmable almost-full/almost-empty flags, sticky overflow/underflow error bits and a registered read port with an explicit valid strobe. Storage is a separate dual-port register-file sub-module, so that the same block can later back a distributed-RAM or BRAM variant.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_regfile.sv | 28 ++
 rtl/param_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the parametrised FIFO family.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_AW_DEF    = 4;

  // Status flags decoded from the occupancy count.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Ceiling log2, for callers sizing AW from a required depth.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Dual-port register file: synchronous write, asynchronous read.
// Kept separate so a distributed-RAM or BRAM macro can replace it.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int AW    = FIFO_AW_DEF
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [AW-1:0]    i_ra,
  output logic [WIDTH-1:0] o_rd
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with registered read port, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int AW       = FIFO_AW_DEF,
  parameter int AF_LEVEL = (1 << AW) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LP_AE    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  fifo_flags_t      w_flags;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [WIDTH-1:0] w_rd_data;

  // Flags are pure decodes of the occupancy count.
  always_comb begin
    w_flags              = '0;
    w_flags.full         = (r_count == LP_DEPTH);
    w_flags.empty        = (r_count == '0);
    w_flags.almost_full  = (r_count >= LP_AF);
    w_flags.almost_empty = (r_count <= LP_AE);
  end

  // A push into a full FIFO is still legal when a pop frees the oldest slot
  // in the same cycle; the async read sees the old entry before the write.
  assign w_push_ok = i_push && (!w_flags.full || i_pop);
  assign w_pop_ok  = i_pop && !w_flags.empty;
  assign w_ovf_evt = i_push && w_flags.full && !i_pop;
  assign w_unf_evt = i_pop && w_flags.empty;

  fifo_regfile #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_regfile (
    .i_clk (i_clk),
    .i_we  (w_push_ok),
    .i_wa  (r_wp),
    .i_wd  (i_din),
    .i_ra  (r_rp),
    .o_rd  (w_rd_data)
  );

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port: data holds between pops, valid is a 1-cycle strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_pop_ok;
      if (w_pop_ok) r_dout <= w_rd_data;
    end
  end

  // Sticky error bits; a new error event beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt || (r_overflow  && !i_err_clr);
      r_underflow <= w_unf_evt || (r_underflow && !i_err_clr);
    end
  end

  assign o_dout         = r_dout;
  assign o_dout_valid   = r_dout_valid;
  assign o_count        = r_count;
  assign o_full         = w_flags.full;
  assign o_empty        = w_flags.empty;
  assign o_almost_full  = w_flags.almost_full;
  assign o_almost_empty = w_flags.almost_empty;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
